// File: rtl/or_batch_sched.sv
// Purpose : round-robin scheduler that shares one OR-reduce accumulator among NUM_REQ requesters.
// Latency : 1 cycle to arbitrate, 1 word/cycle while granted, result registered 1 cycle after batch close.
// Backpress: result is held in DONE until out_ready; no new grant is issued while a result is pending.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester word handshake (req_ready is one-hot or zero)
//   req_data            requester r word at [BIT*r +: BIT]
//   req_last            final word of the requester's batch
//   out_valid/out_ready result handshake, outputs held stable while out_valid && !out_ready
//   out_data            OR of all accepted words in the batch
//   out_id              requester that owned the batch
//   out_count           number of words accepted (1..NUMBER_INPUT)
//   out_trunc           batch closed at NUMBER_INPUT words without req_last
//
// Optional feature: define OR_BATCH_SKIP_ZERO_EN to drop batches whose OR result is all-zero
// (the FSM returns straight to IDLE and the round-robin pointer still advances).
module or_batch_sched #(
  parameter int BIT          = 29,
  parameter int NUMBER_INPUT = 16,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int CNT_W        = $clog2(NUMBER_INPUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*BIT-1:0] req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT-1:0]         out_data,
  output logic [ID_W-1:0]        out_id,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_trunc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [BIT-1:0]   acc;
  logic [CNT_W-1:0] cnt;

  logic [ID_W-1:0]  pick;
  logic             any_vld;
  int               idx;

  logic [BIT-1:0]   g_word;
  logic             g_vld;
  logic             g_last;
  logic             accept;
  logic             close;
  logic             load_out;
  logic [BIT-1:0]   acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ID_W-1:0]  rr_nxt;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester at or after rr_ptr, with wrap.
  // Scanning offsets from highest to lowest lets the smallest offset win.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick    = rr_ptr;
    any_vld = 1'b0;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req_valid[idx]) begin
        pick    = ID_W'(idx);
        any_vld = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted lane view. Only the registered grant steers the datapath, so
  // non-granted requesters can never be accepted whatever they drive.
  // ---------------------------------------------------------------------------
  assign g_word  = req_data[int'(grant)*BIT +: BIT];
  assign g_vld   = req_valid[grant];
  assign g_last  = req_last[grant];

  assign accept  = (state == ACCUM) && g_vld;
  assign acc_nxt = acc | g_word;
  assign cnt_nxt = cnt + 1'b1;
  assign close   = accept && (g_last || (cnt_nxt == CNT_W'(NUMBER_INPUT)));
  assign rr_nxt  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // req_ready decodes from state and grant registers only: no path from req_valid.
  always_comb begin
    req_ready = '0;
    if (state == ACCUM) begin
      req_ready[grant] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and result load strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_vld) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (close) begin
`ifdef OR_BATCH_SKIP_ZERO_EN
          // An all-zero batch is dropped silently; it still consumed its turn.
          if (acc_nxt == '0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end
`else
          state_nxt = DONE;
          load_out  = 1'b1;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      // out_valid mirrors "in DONE" one cycle early so it is a true flop output.
      out_valid <= (state_nxt == DONE);

      if ((state == IDLE) && any_vld) begin
        grant <= pick;
        acc   <= '0;
        cnt   <= '0;
      end

      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end

      if (close) begin
        rr_ptr <= rr_nxt;
      end

      // Result captured from the closing word directly, so out_valid follows
      // the last accept by exactly one cycle.
      if (load_out) begin
        out_data  <= acc_nxt;
        out_id    <= grant;
        out_count <= cnt_nxt;
        out_trunc <= ~g_last;
      end
    end
  end

endmodule

// File: tb/tb_or_batch_sched.sv
// Purpose : self-checking bench for or_batch_sched against a queue-based behavioural model.
// Latency : model tracks arbitration/accumulate/result phases from the documented rules.
// Backpress: random req_valid gaps and out_ready stalls are driven throughout.
module tb_or_batch_sched;

  localparam int BIT   = 29;
  localparam int NI    = 16;
  localparam int NR    = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 5;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic [NR-1:0]         req_valid = '0;
  logic [NR*BIT-1:0]     req_data  = '0;
  logic [NR-1:0]         req_last  = '0;
  logic [NR-1:0]         req_ready;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [BIT-1:0]        out_data;
  logic [ID_W-1:0]       out_id;
  logic [CNT_W-1:0]      out_count;
  logic                  out_trunc;

  always #5 clk = ~clk;

  or_batch_sched #(
    .BIT(BIT), .NUMBER_INPUT(NI), .NUM_REQ(NR), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_count(out_count), .out_trunc(out_trunc)
  );

  typedef struct packed {
    logic [BIT-1:0] data;
    logic           last;
  } word_t;

  typedef struct packed {
    logic [BIT-1:0]   data;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;
    logic             trunc;
  } res_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc    = 0;
  int      vprob  = 100;
  int      rprob  = 100;
  int      acc_cnt [NR];
  word_t   wq [NR][$];
  res_t    dut_log[$];
  logic [NR-1:0] acc_mask = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [BIT-1:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    wq[r].push_back(w);
  endtask

  // ---------------------------------------------------------------------------
  // Requester driver: presents queue heads, pops on accepted handshakes.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (acc_mask[r] && rst_n && wq[r].size() > 0) begin
        void'(wq[r].pop_front());
        acc_cnt[r]++;
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (wq[r].size() > 0 && $urandom_range(99) < vprob) begin
        req_valid[r]              = 1'b1;
        req_data[BIT*r +: BIT]    = wq[r][0].data;
        req_last[r]               = wq[r][0].last;
      end else begin
        req_valid[r]              = 1'b0;
        req_data[BIT*r +: BIT]    = BIT'($urandom);
        req_last[r]               = 1'($urandom_range(1));
      end
    end
    out_ready = ($urandom_range(99) < rprob);
    #1;
    acc_mask = req_valid & req_ready;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: owner = granted requester (-1 none), pending result flag.
  // ---------------------------------------------------------------------------
  int             m_owner = -1;
  int             m_rr    = 0;
  int             m_cnt   = 0;
  int             m_cand  = 0;
  logic           m_pend  = 1'b0;
  logic           m_found = 1'b0;
  logic [BIT-1:0] m_acc   = '0;
  res_t           m_res   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_rr    = 0;
      m_pend  = 1'b0;
      m_acc   = '0;
      m_cnt   = 0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 1'b0;
    end else if (m_owner < 0) begin
      m_found = 1'b0;
      for (int i = 0; i < NR; i++) begin
        m_cand = (m_rr + i) % NR;
        if (!m_found && req_valid[m_cand]) begin
          m_owner = m_cand;
          m_found = 1'b1;
        end
      end
      m_acc = '0;
      m_cnt = 0;
    end else if (req_valid[m_owner]) begin
      m_acc = m_acc | req_data[BIT*m_owner +: BIT];
      m_cnt = m_cnt + 1;
      if (req_last[m_owner] || m_cnt == NI) begin
        m_res.data  = m_acc;
        m_res.id    = m_owner[ID_W-1:0];
        m_res.cnt   = m_cnt[CNT_W-1:0];
        m_res.trunc = !req_last[m_owner];
        m_rr        = (m_owner + 1) % NR;
        m_owner     = -1;
        m_pend      = 1'b1;
`ifdef OR_BATCH_SKIP_ZERO_EN
        if (m_acc == '0) m_pend = 1'b0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model; logs every handed-off result.
  // ---------------------------------------------------------------------------
  logic [NR-1:0] exp_rdy;
  res_t          got;

  always @(negedge clk) begin
    #2;
    cyc++;
    exp_rdy = '0;
    if (m_owner >= 0) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("out_valid", out_valid, m_pend);
    if (m_pend) begin
      chk("out_data",  out_data,  m_res.data);
      chk("out_id",    out_id,    m_res.id);
      chk("out_count", out_count, m_res.cnt);
      chk("out_trunc", out_trunc, m_res.trunc);
    end
    if (out_valid && out_ready) begin
      got.data  = out_data;
      got.id    = out_id;
      got.cnt   = out_count;
      got.trunc = out_trunc;
      dut_log.push_back(got);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_id",    out_id,    0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_trunc", out_trunc, 0);
    for (int r = 0; r < NR; r++) begin
      wq[r].delete();
      acc_cnt[r] = 0;
    end
    dut_log.delete();
    vprob = 100;
    rprob = 100;
    repeat (3) @(negedge clk);
    #4 rst_n = 1'b1;
  endtask

  task automatic wait_results(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (dut_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (dut_log.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d results expected %0d", nm, dut_log.size(), n);
    end
  endtask

  task automatic chk_res(input string nm, input int i, input logic [BIT-1:0] d,
                         input int id, input int c, input logic t);
    if (i >= dut_log.size()) begin
      checks++;
      errors++;
      $display("FAIL %s result %0d missing: got %0d results", nm, i, dut_log.size());
    end else begin
      chk({nm, "_data"},  dut_log[i].data,  d);
      chk({nm, "_id"},    dut_log[i].id,    id);
      chk({nm, "_count"}, dut_log[i].cnt,   c);
      chk({nm, "_trunc"}, dut_log[i].trunc, t);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int n_exp;
    for (int r = 0; r < NR; r++) acc_cnt[r] = 0;

    // Three-word batch from r2.
    do_reset();
    push(2, 29'h1, 1'b0);
    push(2, 29'h100, 1'b0);
    push(2, 29'h1000_0000, 1'b1);
    wait_results(1, 100, "single");
    chk_res("single", 0, 29'h1000_0101, 2, 3, 1'b0);

    // All four requesters, one-word batches: strict rotation.
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int r = 0; r < NR; r++) push(r, BIT'(r + 1), 1'b1);
    wait_results(8, 200, "rr");
    for (int i = 0; i < 5; i++) chk_res("rr", i, BIT'((i % NR) + 1), i % NR, 1, 1'b0);

    // Truncation at NUMBER_INPUT, remainder forms the next batch.
    do_reset();
    for (int j = 0; j < 20; j++) push(1, BIT'(1) << j, (j == 19));
    wait_results(2, 200, "trunc");
    chk_res("trunc0", 0, 29'h0_FFFF, 1, 16, 1'b1);
    chk_res("trunc1", 1, 29'hF_0000, 1, 4, 1'b0);

    // Result held while out_ready low; other requesters wait.
    do_reset();
    rprob = 0;
    push(0, 29'h55, 1'b1);
    push(1, 29'hAA, 1'b1);
    push(2, 29'h3, 1'b1);
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data",  out_data,  29'h55);
      chk("hold_ready", req_ready, 0);
      tick();
    end
    rprob = 100;
    tick();
    tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", req_ready, 0);
    tick();
    chk("regrant_ready", req_ready, 4'b0010);
    wait_results(3, 100, "hold");
    chk_res("hold", 0, 29'h55, 0, 1, 1'b0);

    // Reset after 5 accepted words discards the partial batch.
    do_reset();
    for (int j = 0; j < 10; j++) push(3, BIT'(1) << j, (j == 9));
    k = 0;
    while (acc_cnt[3] < 5 && k < 100) begin
      tick();
      k++;
    end
    chk("pre_rst_accepts", acc_cnt[3], 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", req_ready, 0);
    push(0, 29'h7, 1'b1);
    repeat (2) @(negedge clk);
    #4 rst_n = 1'b1;
    wait_results(2, 100, "midrst");
    chk_res("midrst0", 0, 29'h7, 0, 1, 1'b0);
    chk_res("midrst1", 1, 29'h3E0, 3, 5, 1'b0);

    // All-zero batch from r3.
    do_reset();
    push(3, 29'h0, 1'b0);
    push(3, 29'h0, 1'b1);
    repeat (15) tick();
`ifdef OR_BATCH_SKIP_ZERO_EN
    chk("zero_skipped", dut_log.size(), 0);
    n_exp = 0;
`else
    chk_res("zero", 0, 29'h0, 3, 2, 1'b0);
    n_exp = 1;
`endif
    push(1, 29'h2, 1'b1);
    push(0, 29'h1, 1'b1);
    wait_results(n_exp + 2, 100, "zero_next");
    chk_res("zero_next", n_exp, 29'h1, 0, 1, 1'b0);

    // Randomized traffic with valid gaps, consumer stalls and one mid-run reset.
    do_reset();
    vprob = 70;
    rprob = 60;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (wq[r].size() < 3 && $urandom_range(3) == 0) begin
          if ($urandom_range(7) == 0) push(r, '0, ($urandom_range(3) == 0));
          else push(r, BIT'($urandom) & BIT'($urandom), ($urandom_range(3) == 0));
        end
      end
      if (c == 1500) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #4 rst_n = 1'b1;
      end
      tick();
    end
    vprob = 100;
    rprob = 100;
    for (int r = 0; r < NR; r++) push(r, 29'h1, 1'b1);
    k = 0;
    while ((wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size()) > 0 && k < 500) begin
      tick();
      k++;
    end
    chk("drain_empty", wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size(), 0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/or_batch_sched.md
# or_batch_sched

Round-robin scheduler that shares one OR-reduction datapath among NUM_REQ requesters. Each requester streams a batch of BIT-wide words over a valid/ready handshake. The block grants one requester at a time and OR-accumulates its words, up to NUMBER_INPUT per batch. The reduced word is returned with requester ID and word count on a held output handshake. It sits upstream of the result consumers in the OR-reduce subsystem.

## Interface
- BIT, 29, data word width
- NUMBER_INPUT, 16, maximum words per batch
- NUM_REQ, 4, number of requesters (≥2)
- ID_W, $clog2(NUM_REQ), requester ID width
- CNT_W, $clog2(NUMBER_INPUT+1), word count width

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*BIT  word of requester r at [BIT*r +: BIT]
- req_last  in  NUM_REQ  marks final word of requester's batch
- req_ready  out  NUM_REQ  one-hot or zero; word accepted on valid&ready
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  BIT  OR of all accepted batch words
- out_id  out  ID_W  requester that owned the batch
- out_count  out  CNT_W  words accepted in batch (1..NUMBER_INPUT)
- out_trunc  out  1  batch closed at NUMBER_INPUT words without req_last

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - If any req_valid is set, grant the first requester at or after rr_ptr, scanning upward with wrap.
  - Register grant and ID, clear accumulator and count, go to ACCUM.
  - No words are accepted in IDLE.
- ACCUM:
  - req_ready[grant]=1, all other ready bits 0.
  - On each accepted word: acc |= word, count += 1.
  - Close the batch when the accepted word has req_last=1 (trunc=0), or when count reaches NUMBER_INPUT (trunc = !req_last).
  - On close: rr_ptr = grant+1 mod NUM_REQ, go to DONE.
  - A valid low during ACCUM stalls; the grant is held indefinitely.
- DONE:
  - out_valid=1, outputs stable.
  - On out_valid&out_ready, go to IDLE.
- A truncated requester's remaining words form a new batch. It re-arbitrates normally and gets no priority boost.
- Requesters not granted are never accepted, regardless of req_valid or req_last.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, out_valid=0, out_data=0, out_id=0, out_count=0, out_trunc=0.
- Reset mid-batch discards the partial accumulation. No output is produced for it.

## Timing
- All outputs are registered, except req_ready, which decodes from state and grant registers only. req_ready has no combinational path from req_valid.
- Arbitration costs 1 cycle: valid seen in IDLE at cycle t → req_ready high at t+1.
- Single-word batch: accepted at t+1 → out_valid at t+2.
- Close-to-result latency: last word accepted at cycle n → out_valid at n+1.
- Result hold: out_valid stays high and outputs stay stable until accepted.
- Minimum batch turnaround is 3 cycles: IDLE, ACCUM, DONE with out_ready held high.
- No back-to-back grant without an IDLE cycle.

## Configuration
- OR_BATCH_SKIP_ZERO_EN
- Defined:
  - A batch whose final OR result is all-zero produces no output.
  - On close, the FSM goes directly to IDLE and rr_ptr still advances.
- Undefined:
  - Every batch, including all-zero, passes through DONE and is presented.

## Test plan
- Single requester, BIT=29, NUM_REQ=4: r2 sends 0x1, 0x100, 0x10000000 with last on the third word → out_data=0x10000101, out_id=2, out_count=3, out_trunc=0, out_valid 1 cycle after the third accept.
- All four requesters valid continuously, one-word batches after reset → grant order 0,1,2,3,0. Each out_id matches the order, and no requester is served twice before the others.
- r1 streams 20 words of value 1<<k without last, NUMBER_INPUT=16 → first result out_count=16, out_trunc=1, out_data=0xFFFF. The next r1 batch holds the remaining 4 words, covering bits 16-19.
- out_ready held low 10 cycles in DONE while other requesters are valid → out_valid and data stay stable, req_ready stays all-zero. IDLE is entered the cycle after out_ready rises.
- Assert rst_n low after 5 accepted words of a batch → out_valid=0 and req_ready=0 immediately. After release, the first grant goes to r0 if valid.
- r3 sends two zero words with last: with OR_BATCH_SKIP_ZERO_EN defined, no out_valid and the next grant starts at r0; undefined, out_data=0, out_count=2.
